// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, 40-bit frame capture,
// checksum verification and periodic polling.
module dht11_reader #(
  parameter int unsigned CLK_HZ       = 12_000_000,
  parameter int unsigned START_LOW_US = 20000,
  parameter int unsigned TIMEOUT_US   = 200,
  parameter int unsigned THRESH_US    = 48,
  parameter int unsigned POLL_MS      = 2000
) (
  input  logic       hclk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       busy,
  output logic       err_checksum,
  output logic       err_timeout
);

  localparam int unsigned DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PLW = $clog2(POLL_MS + 1);

  localparam logic [PW-1:0]  PRE_LAST   = PW'(DIV - 1);
  localparam logic [14:0]    START_LAST = 15'(START_LOW_US - 1);
  localparam logic [14:0]    TMO_LIM    = 15'(TIMEOUT_US);
  localparam logic [14:0]    BIT_THR    = 15'(THRESH_US);
  localparam logic [PLW-1:0] POLL_LAST  = PLW'(POLL_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_REL,
    S_RESP_LO,
    S_RESP_HI,
    S_BIT_LO,
    S_BIT_HI,
    S_CHECK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic           sync1;
  logic           sync2;
  logic           prev;
  logic           rise;
  logic           fall;

  logic [PW-1:0]  pre_cnt;
  logic           us_tick;
  logic [14:0]    phase;
  logic [9:0]     ms_div;
  logic           ms_tick;
  logic [PLW-1:0] poll_cnt;
  logic           poll_due;

  logic [39:0]    frame;
  logic [5:0]     bit_cnt;
  logic [7:0]     sum;
  logic           bit_val;
  logic           timed_out;

  logic           start_rd;
  logic           shift_en;
  logic           tmo;
  logic           load_ok;
  logic           load_bad;

  // Pin synchroniser; idles high like the pulled-up line
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= dht_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  // Free-running microsecond prescaler
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (us_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign us_tick = (pre_cnt == PRE_LAST);

  // Per-state elapsed microseconds, saturating, zeroed on transitions
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (state_nxt != state) begin
      phase <= '0;
    end else if (us_tick && (phase != '1)) begin
      phase <= phase + 1'b1;
    end
  end

  assign ms_tick = us_tick && (ms_div == 10'd999);

  // Millisecond divider, realigned whenever a read starts
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      ms_div <= '0;
    end else if (start_rd) begin
      ms_div <= '0;
    end else if (ms_tick) begin
      ms_div <= '0;
    end else if (us_tick) begin
      ms_div <= ms_div + 1'b1;
    end
  end

  // Poll timer; holds its expiry until IDLE can act on it
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (start_rd) begin
      poll_cnt <= '0;
    end else if (ms_tick && !poll_due) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign poll_due  = (poll_cnt == POLL_LAST);
  assign timed_out = (phase > TMO_LIM);
  assign bit_val   = (phase > BIT_THR);
  assign sum       = frame[39:32] + frame[31:24]
                   + frame[23:16] + frame[15:8];

  // State register
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    shift_en  = 1'b0;
    tmo       = 1'b0;
    load_ok   = 1'b0;
    load_bad  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (poll_due || trig) begin
          start_rd  = 1'b1;
          state_nxt = S_START_LOW;
        end
      end
      S_START_LOW: begin
        if (us_tick && (phase >= START_LAST)) begin
          state_nxt = S_REL;
        end
      end
      S_REL: begin
        if (fall) begin
          state_nxt = S_RESP_LO;
        end else if (timed_out) begin
          tmo = 1'b1;
        end
      end
      S_RESP_LO: begin
        if (rise) begin
          state_nxt = S_RESP_HI;
        end else if (timed_out) begin
          tmo = 1'b1;
        end
      end
      S_RESP_HI: begin
        if (fall) begin
          state_nxt = S_BIT_LO;
        end else if (timed_out) begin
          tmo = 1'b1;
        end
      end
      S_BIT_LO: begin
        if (rise) begin
          state_nxt = S_BIT_HI;
        end else if (timed_out) begin
          tmo = 1'b1;
        end
      end
      S_BIT_HI: begin
        if (fall) begin
          shift_en  = 1'b1;
          state_nxt = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LO;
        end else if (timed_out) begin
          tmo = 1'b1;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        if (sum == frame[7:0]) begin
          load_ok = 1'b1;
        end else begin
          load_bad = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (tmo) begin
      state_nxt = S_IDLE;
    end
  end

  // Frame capture, published values and status flags
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      frame        <= '0;
      bit_cnt      <= '0;
      humidity     <= '0;
      temperature  <= '0;
      data_valid   <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      data_valid <= load_ok;
      if (start_rd) begin
        frame        <= '0;
        bit_cnt      <= '0;
        err_checksum <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (shift_en) begin
        frame   <= {frame[38:0], bit_val};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (tmo) begin
        err_timeout <= 1'b1;
      end
      if (load_bad) begin
        err_checksum <= 1'b1;
      end
      if (load_ok) begin
        humidity    <= frame[39:32];
        temperature <= frame[23:16];
      end
    end
  end

  assign busy   = (state != S_IDLE);
  assign dht_oe = (state == S_START_LOW);

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 sensor, reference
// model of read outcomes and a scoreboard checked at each read end.
module tb_dht11_reader;

  localparam int CLK_HZ       = 1_000_000;
  localparam int START_LOW_US = 100;
  localparam int TIMEOUT_US   = 200;
  localparam int THRESH_US    = 48;
  localparam int POLL_MS      = 1;

  typedef enum int {SC_FRAME, SC_SILENT, SC_STUCK} sc_kind_e;
  typedef enum int {EX_VALID, EX_CKSUM, EX_TMO} ex_kind_e;

  typedef struct {
    sc_kind_e    kind;
    logic [39:0] frame;
    int          w0;
    int          w1;
    bit          mark;
  } scen_t;

  typedef struct {
    ex_kind_e   kind;
    logic [7:0] h;
    logic [7:0] t;
    bit         rel_tmo;
    int         rel_time;
  } exp_t;

  logic       hclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       data_valid;
  logic       busy;
  logic       err_checksum;
  logic       err_timeout;
  logic       sens_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int starts = 0;
  int served = 0;
  int rel_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int rise_mark = 0;
  int reads_done = 0;
  int stray = 0;
  int abort_req = 0;
  int abort_seen = 0;
  int marked_bit = -1;
  bit sens_busy = 1'b0;
  logic [7:0] mdl_h = 8'd0;
  logic [7:0] mdl_t = 8'd0;

  scen_t scen_q[$];
  exp_t  exp_q[$];
  int    widths[$];

  assign dht_in = ~(dht_oe | sens_low);

  dht11_reader #(
    .CLK_HZ      (CLK_HZ),
    .START_LOW_US(START_LOW_US),
    .TIMEOUT_US  (TIMEOUT_US),
    .THRESH_US   (THRESH_US),
    .POLL_MS     (POLL_MS)
  ) dut (
    .hclk        (hclk),
    .rst_n       (rst_n),
    .trig        (trig),
    .dht_in      (dht_in),
    .dht_oe      (dht_oe),
    .humidity    (humidity),
    .temperature (temperature),
    .data_valid  (data_valid),
    .busy        (busy),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc++;

  always @(posedge dht_oe) begin
    rise_cnt++;
    rise_cyc = cyc;
  end

  always @(negedge dht_oe) begin
    if (rst_n) begin
      starts++;
      rel_cyc = cyc;
      widths.push_back(cyc - rise_cyc);
    end
  end

  task automatic check(input string name, input longint act,
                       input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  // Reference model: outcome of one read from the sensor's behaviour
  task automatic predict(input scen_t s);
    exp_t e;
    int   total;
    e.rel_tmo  = (s.kind == SC_SILENT);
    e.rel_time = rel_cyc;
    if (s.kind == SC_FRAME) begin
      total = 0;
      for (int b = 1; b < 5; b++) total += int'(s.frame[8*b +: 8]);
      if ((total % 256) == int'(s.frame[7:0])) begin
        e.kind = EX_VALID;
        mdl_h  = s.frame[39:32];
        mdl_t  = s.frame[23:16];
      end else begin
        e.kind = EX_CKSUM;
      end
    end else begin
      e.kind = EX_TMO;
    end
    e.h = mdl_h;
    e.t = mdl_t;
    exp_q.push_back(e);
  endtask

  function automatic bit aborted();
    return abort_req != abort_seen;
  endfunction

  task automatic hold(input bit drive_low, input int n);
    sens_low = drive_low;
    for (int k = 0; k < n; k++) begin
      @(negedge hclk);
      if (aborted()) break;
    end
  endtask

  task automatic play(input scen_t s);
    int w;
    hold(1'b0, $urandom_range(20, 40));
    if (aborted()) return;
    hold(1'b1, $urandom_range(75, 85));
    if (aborted()) return;
    hold(1'b0, $urandom_range(75, 85));
    if (aborted()) return;
    for (int i = 0; i < 40; i++) begin
      if (s.mark) marked_bit = i;
      hold(1'b1, $urandom_range(45, 55));
      if (aborted()) return;
      if (s.kind == SC_STUCK && i == 17) w = 300;
      else if (s.frame[39-i]) w = (s.w1 > 0) ? s.w1 : $urandom_range(50, 75);
      else w = (s.w0 > 0) ? s.w0 : $urandom_range(20, 46);
      hold(1'b0, w);
      if (aborted()) return;
      if (s.kind == SC_STUCK && i == 17) return;
    end
    hold(1'b1, $urandom_range(45, 55));
  endtask

  // Sensor: answers each released start pulse with the next scenario
  initial begin : sensor
    scen_t s;
    forever begin
      wait (starts != served);
      served++;
      sens_busy  = 1'b1;
      abort_seen = abort_req;
      marked_bit = -1;
      if (scen_q.size() > 0) begin
        s = scen_q.pop_front();
      end else begin
        s.kind = SC_SILENT;
        s.frame = '0;
        s.w0 = 0;
        s.w1 = 0;
        s.mark = 1'b0;
      end
      predict(s);
      if (s.kind != SC_SILENT) play(s);
      sens_low = 1'b0;
      if (aborted()) begin
        abort_seen = abort_req;
        served = starts;
      end
      sens_busy = 1'b0;
    end
  end

  // Monitor: checks DUT state in the first IDLE cycle after each read
  initial begin : monitor
    bit   pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge hclk);
      if (!rst_n) begin
        pb = 1'b0;
        rise_mark = rise_cnt;
        continue;
      end
      if (data_valid && !(pb && !busy)) stray++;
      if (pb && !busy) begin
        reads_done++;
        if (exp_q.size() == 0) begin
          check("scoreboard entry present", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("data_valid", data_valid, e.kind == EX_VALID);
          check("err_checksum", err_checksum, e.kind == EX_CKSUM);
          check("err_timeout", err_timeout, e.kind == EX_TMO);
          check("humidity", humidity, e.h);
          check("temperature", temperature, e.t);
          check("dht_oe after read", dht_oe, 0);
          if (e.rel_tmo)
            check_range("no-sensor timeout latency", cyc - e.rel_time,
                        198, 210);
        end
        check("start pulses per read", rise_cnt - rise_mark, 1);
        rise_mark = rise_cnt;
        while (widths.size() > 0)
          check_range("start pulse width", widths.pop_front(),
                      START_LOW_US - 1, START_LOW_US + 1);
      end
      pb = busy;
    end
  end

  function automatic scen_t mk_frame(input bit bad);
    scen_t s;
    logic [7:0] b0, b1, b2, b3, b4;
    b0 = 8'($urandom);
    b1 = 8'($urandom_range(0, 9));
    b2 = 8'($urandom);
    b3 = 8'($urandom_range(0, 9));
    b4 = b0 + b1 + b2 + b3;
    if (bad) b4 = b4 ^ 8'($urandom_range(1, 255));
    s.kind  = SC_FRAME;
    s.frame = {b0, b1, b2, b3, b4};
    s.w0    = 0;
    s.w1    = 0;
    s.mark  = 1'b0;
    return s;
  endfunction

  function automatic scen_t mk_fixed(input sc_kind_e k,
                                     input logic [39:0] f,
                                     input int w0, input int w1);
    scen_t s;
    s.kind  = k;
    s.frame = f;
    s.w0    = w0;
    s.w1    = w1;
    s.mark  = 1'b0;
    return s;
  endfunction

  task automatic wait_reads(input int target, input int budget);
    int k;
    k = 0;
    while (reads_done < target && k < budget) begin
      @(negedge hclk);
      k++;
    end
    check("reads finished within budget", reads_done >= target, 1);
  endtask

  task automatic do_reset();
    int k;
    @(posedge hclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset dht_oe", dht_oe, 0);
    check("reset busy", busy, 0);
    check("reset humidity", humidity, 0);
    check("reset temperature", temperature, 0);
    check("reset flags", {data_valid, err_checksum, err_timeout}, 0);
    exp_q.delete();
    mdl_h = 8'd0;
    mdl_t = 8'd0;
    abort_req++;
    k = 0;
    while (sens_busy && k < 1000) begin
      @(negedge hclk);
      k++;
    end
    check("sensor model idle after reset", sens_busy, 0);
    repeat (4) @(negedge hclk);
  endtask

  task automatic release_reset();
    @(posedge hclk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge hclk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    scen_t s;
    int    n;
    int    base;

    repeat (3) @(negedge hclk);
    check("power-up dht_oe", dht_oe, 0);
    check("power-up busy", busy, 0);
    check("power-up data",
          {humidity, temperature, data_valid, err_checksum, err_timeout}, 0);

    scen_q.push_back(mk_fixed(SC_FRAME, 40'h37_00_19_00_50, 26, 70));
    scen_q.push_back(mk_fixed(SC_FRAME, 40'h40_00_1E_00_5F, 26, 70));
    scen_q.push_back(mk_fixed(SC_SILENT, 40'h0, 0, 0));
    s = mk_frame(1'b0);
    s.kind = SC_STUCK;
    scen_q.push_back(s);
    scen_q.push_back(mk_frame(1'b0));
    scen_q.push_back(mk_fixed(SC_FRAME, 40'hFF_01_02_00_02, 47, 50));
    for (int i = 0; i < 4; i++)
      scen_q.push_back(mk_frame($urandom_range(0, 3) == 0));
    base = reads_done;
    n = scen_q.size();

    release_reset();
    wait_reads(base + n, 50000);

    s = mk_frame(1'b0);
    s.mark = 1'b1;
    scen_q.push_back(s);
    n = 0;
    while (marked_bit != 10 && n < 12000) begin
      @(negedge hclk);
      n++;
    end
    check("reached bit 10 of marked frame", marked_bit, 10);
    do_reset();
    scen_q.delete();
    scen_q.push_back(mk_frame(1'b0));
    release_reset();
    n = 0;
    while (n < 3000) begin
      @(posedge hclk);
      #1;
      n++;
      if (dht_oe) break;
    end
    check_range("first start after reset", n, 995, 1010);
    wait_reads(reads_done + 1, 8000);

    do_reset();
    scen_q.delete();
    scen_q.push_back(mk_frame(1'b0));
    release_reset();
    repeat (300) @(negedge hclk);
    trig = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge hclk);
      #1;
      n++;
      if (dht_oe) break;
    end
    trig = 1'b0;
    check_range("trig start latency", n, 1, 2);
    wait_reads(reads_done + 1, 8000);

    for (int i = 0; i < 2; i++) scen_q.push_back(mk_frame(i == 1));
    @(negedge hclk);
    trig = 1'b1;
    wait_reads(reads_done + 2, 14000);
    @(negedge hclk);
    trig = 1'b0;

    check("stray data_valid pulses", stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
